// File: rtl/menu_pkg.sv
// Shared constants for the on-screen menu input controller.
// Row indices, VGA placement of menu lines and default button timing.
package menu_pkg;

  localparam logic [2:0] ROW_AXIS = 3'd0;
  localparam logic [2:0] ROW_GRID = 3'd1;
  localparam logic [2:0] ROW_TICK = 3'd2;
  localparam logic [2:0] ROW_WAVE = 3'd3;
  localparam logic [2:0] ROW_IMBA = 3'd4;
  localparam logic [2:0] ROW_LAST = 3'd4;

  localparam int MENU_BASE_Y  = 688;
  localparam int MENU_PITCH_Y = 24;

  localparam int DEF_DEBOUNCE_CYCLES = 1080000;
  localparam int DEF_REPEAT_DELAY    = 54000000;
  localparam int DEF_REPEAT_PERIOD   = 16200000;

  // Flag vector bit i belongs to row i; all on except imba.
  localparam logic [4:0] FLAGS_RST = 5'b01111;

  function automatic logic [11:0] row_y(input logic [2:0] row);
    return 12'(MENU_BASE_Y) + 12'(MENU_PITCH_Y) * {9'd0, row};
  endfunction

endpackage

// File: rtl/menu_if.sv
// Button inputs and mode/cursor outputs of the menu controller.
// master: controller side (buttons in, flags/cursor out); slave: the rest.
interface menu_if;

  logic        BTN_UP;
  logic        BTN_DOWN;
  logic        BTN_CENTRE;
  logic        Menu_Sw;
  logic        Axis_On;
  logic        Grid_On;
  logic        Tick_On;
  logic        Wave_On;
  logic        Imba_On;
  logic [2:0]  Cursor_Row;
  logic [11:0] Cursor_Vert_Coord;

  modport master (
    input  BTN_UP, BTN_DOWN, BTN_CENTRE, Menu_Sw,
    output Axis_On, Grid_On, Tick_On, Wave_On, Imba_On,
    output Cursor_Row, Cursor_Vert_Coord
  );

  modport slave (
    output BTN_UP, BTN_DOWN, BTN_CENTRE, Menu_Sw,
    input  Axis_On, Grid_On, Tick_On, Wave_On, Imba_On,
    input  Cursor_Row, Cursor_Vert_Coord
  );

endinterface

// File: rtl/menu_controller_btn_conditioner.sv
// Synchronise, debounce and optionally auto-repeat one raw pushbutton.
// Ports: CLK, RST_N, BTN_RAW (async) -> PRESS_PULSE (one-cycle, registered).
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN_RAW,
  output logic PRESS_PULSE
);

  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_TOP = DW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          deb;
  logic [DW-1:0] cnt;
  logic          db_done;
  logic          rep_hit;

  assign db_done = (s2 != deb) && (cnt == DB_TOP);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      deb         <= 1'b0;
      cnt         <= '0;
      PRESS_PULSE <= 1'b0;
    end else begin
      s1 <= BTN_RAW;
      s2 <= s1;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == DB_TOP) begin
        cnt <= '0;
        deb <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
      PRESS_PULSE <= (db_done && s2) || rep_hit;
    end
  end

  if (REPEAT_EN) begin : g_rep
    localparam int RW =
      (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam logic [RW-1:0] R_TOP = RW'(REPEAT_DELAY - 1);
    // After each repeat, rewind so the next hit is one period away.
    localparam logic [RW-1:0] R_RLD =
      RW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RW-1:0] rcnt;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        rcnt <= '0;
      end else if (!deb) begin
        rcnt <= '0;
      end else if (rcnt == R_TOP) begin
        rcnt <= R_RLD;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end

    assign rep_hit = deb && (rcnt == R_TOP);
  end else begin : g_norep
    assign rep_hit = 1'b0;
  end

endmodule

// File: rtl/menu_controller.sv
// Menu input controller: buttons -> persistent mode flags and row cursor.
// Ports: CLK, RST_N, bus (menu_if.master: buttons, Menu_Sw, flags, cursor).
module menu_controller
  import menu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic   CLK,
  input  logic   RST_N,
  menu_if.master bus
);

  logic        up_p;
  logic        dn_p;
  logic        ce_p;
  logic        menu_q;
  logic        rise;
  logic [2:0]  row;
  logic [2:0]  row_n;
  logic [11:0] coord;
  logic [4:0]  flags;
  logic [4:0]  flags_n;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_EN      (1'b1),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_up (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .BTN_RAW    (bus.BTN_UP),
    .PRESS_PULSE(up_p)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_EN      (1'b1),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_down (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .BTN_RAW    (bus.BTN_DOWN),
    .PRESS_PULSE(dn_p)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_EN      (1'b0),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_centre (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .BTN_RAW    (bus.BTN_CENTRE),
    .PRESS_PULSE(ce_p)
  );

  // Toggle uses the pre-move row; opening the menu or an illegal
  // row both snap to row 0 and swallow any pulse that cycle.
  always_comb begin
    rise    = bus.Menu_Sw & ~menu_q;
    row_n   = row;
    flags_n = flags;
    if (rise || (row > ROW_LAST)) begin
      row_n = ROW_AXIS;
    end else if (bus.Menu_Sw) begin
      if (ce_p) flags_n = flags ^ (5'b00001 << row);
      unique case ({up_p, dn_p})
        2'b10:
          row_n = (row == ROW_AXIS) ? ROW_LAST : row - 3'd1;
        2'b01:
          row_n = (row == ROW_LAST) ? ROW_AXIS : row + 3'd1;
        default: row_n = row;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      menu_q <= 1'b0;
      row    <= ROW_AXIS;
      coord  <= row_y(ROW_AXIS);
      flags  <= FLAGS_RST;
    end else begin
      menu_q <= bus.Menu_Sw;
      row    <= row_n;
      coord  <= row_y(row_n);
      flags  <= flags_n;
    end
  end

  assign bus.Axis_On           = flags[ROW_AXIS];
  assign bus.Grid_On           = flags[ROW_GRID];
  assign bus.Tick_On           = flags[ROW_TICK];
  assign bus.Wave_On           = flags[ROW_WAVE];
  assign bus.Imba_On           = flags[ROW_IMBA];
  assign bus.Cursor_Row        = row;
  assign bus.Cursor_Vert_Coord = coord;

endmodule

// File: tb/tb_menu_controller.sv
// Testbench for menu_controller with short debounce/repeat timing.
// Directed steps plus random presses checked against a row/flag model.
module tb_menu_controller;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  menu_if bus();

  menu_controller #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         m_row;
  logic [4:0] m_flags;
  bit         m_menu;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] flags_now();
    return {bus.Imba_On, bus.Wave_On, bus.Tick_On,
            bus.Grid_On, bus.Axis_On};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".row"}, 32'(bus.Cursor_Row), m_row);
    chk({tag, ".y"}, 32'(bus.Cursor_Vert_Coord), 688 + 24 * m_row);
    chk({tag, ".flags"}, 32'(flags_now()), 32'(m_flags));
  endtask

  // Steps produced by one clean hold of h cycles on UP/DOWN:
  // the press, then one at +RD and every +RP while still held.
  function automatic int steps_for(input int h);
    return (h >= RD) ? 2 + (h - RD) / RP : 1;
  endfunction

  task automatic model_press(input bit u, input bit d, input bit c,
                             input int h);
    int n;
    if (!m_menu) return;
    n = (u || d) ? steps_for(h) : 1;
    if (c) m_flags[m_row] = ~m_flags[m_row];
    for (int i = 0; i < n; i++) begin
      if (u && !d) m_row = (m_row + 4) % 5;
      if (d && !u) m_row = (m_row + 1) % 5;
    end
  endtask

  task automatic press(input bit u, input bit d, input bit c,
                       input int h);
    bus.BTN_UP     = u;
    bus.BTN_DOWN   = d;
    bus.BTN_CENTRE = c;
    cyc(h);
    bus.BTN_UP     = 1'b0;
    bus.BTN_DOWN   = 1'b0;
    bus.BTN_CENTRE = 1'b0;
    cyc(DB + 8);
    model_press(u, d, c, h);
  endtask

  task automatic set_menu(input bit v);
    if (v && !m_menu) m_row = 0;
    m_menu      = v;
    bus.Menu_Sw = v;
    cyc(2);
  endtask

  int exp_seq[7] = '{1, 2, 3, 2, 1, 0, 4};
  int hs[4]      = '{10, 24, 32, 40};

  initial begin
    bus.BTN_UP     = 1'b0;
    bus.BTN_DOWN   = 1'b0;
    bus.BTN_CENTRE = 1'b0;
    bus.Menu_Sw    = 1'b0;
    m_menu         = 1'b0;
    m_row          = 0;
    m_flags        = 5'b01111;
    cyc(2);
    check_all("reset");
    rst_n = 1'b1;
    cyc(2);
    set_menu(1'b1);

    // First DOWN press: step lands 6 cycles after the raw edge,
    // visible on the outputs one cycle later.
    bus.BTN_DOWN = 1'b1;
    cyc(6);
    chk("latency.before", 32'(bus.Cursor_Row), 0);
    cyc(1);
    chk("latency.after", 32'(bus.Cursor_Row), 1);
    cyc(3);
    bus.BTN_DOWN = 1'b0;
    cyc(DB + 8);
    model_press(1'b0, 1'b1, 1'b0, 10);
    check_all("seq0");

    for (int i = 1; i < 7; i++) begin
      press(i >= 3, i < 3, 1'b0, 10);
      chk("seq.row", 32'(bus.Cursor_Row), exp_seq[i]);
      check_all("seq");
    end
    chk("seq.y_end", 32'(bus.Cursor_Vert_Coord), 784);

    // Toggle tick on row 2, then a press with the menu disabled.
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0, 10);
    chk("tick.row", 32'(bus.Cursor_Row), 2);
    press(1'b0, 1'b0, 1'b1, 10);
    chk("tick.flags", 32'(flags_now()), 32'(5'b01011));
    check_all("tick");
    set_menu(1'b0);
    press(1'b0, 1'b0, 1'b1, 10);
    press(1'b0, 1'b1, 1'b0, 10);
    check_all("menu_off");
    set_menu(1'b1);

    // Toggle-and-move in one cycle, then UP+DOWN together.
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0, 10);
    press(1'b0, 1'b1, 1'b1, 10);
    chk("both.flags", 32'(flags_now()), 32'(5'b00011));
    chk("both.row", 32'(bus.Cursor_Row), 4);
    press(1'b1, 1'b1, 1'b0, 10);
    chk("updown.row", 32'(bus.Cursor_Row), 4);
    check_all("updown");

    // Reopening the menu returns the cursor to row 0.
    press(1'b1, 1'b0, 1'b0, 10);
    chk("reopen.pre", 32'(bus.Cursor_Row), 3);
    set_menu(1'b0);
    bus.Menu_Sw = 1'b1;
    m_menu      = 1'b1;
    m_row       = 0;
    cyc(1);
    chk("reopen.row", 32'(bus.Cursor_Row), 0);
    chk("reopen.flags", 32'(flags_now()), 32'(5'b00011));
    check_all("reopen");

    // Bounce never steps; a long hold auto-repeats.
    for (int i = 0; i < 16; i++) begin
      bus.BTN_DOWN = (i % 2 == 0);
      cyc(2);
    end
    chk("bounce.nostep", 32'(bus.Cursor_Row), 0);
    bus.BTN_DOWN = 1'b1;
    cyc(7);
    chk("rep.first", 32'(bus.Cursor_Row), 1);
    cyc(19);
    chk("rep.wait", 32'(bus.Cursor_Row), 1);
    cyc(1);
    chk("rep.plus20", 32'(bus.Cursor_Row), 2);
    cyc(8);
    chk("rep.plus28", 32'(bus.Cursor_Row), 3);
    cyc(5);
    bus.BTN_DOWN = 1'b0;
    cyc(3);
    chk("rep.plus36", 32'(bus.Cursor_Row), 4);
    cyc(DB + 8);
    model_press(1'b0, 1'b1, 1'b0, 40);
    check_all("rep.end");

    // Random presses against the model.
    for (int it = 0; it < 16; it++) begin
      int sel;
      int h;
      bit u;
      bit d;
      bit c;
      sel = int'($urandom_range(0, 5));
      h   = hs[$urandom_range(0, 3)];
      u   = (sel == 0) || (sel == 3) || (sel == 5);
      d   = (sel == 1) || (sel == 4) || (sel == 5);
      c   = (sel == 2) || (sel == 3) || (sel == 4);
      if ($urandom_range(0, 5) == 0) set_menu(!m_menu);
      press(u, d, c, h);
      check_all("rand");
    end
    set_menu(1'b1);

    // Asynchronous reset while buttons bounce.
    press(1'b0, 1'b0, 1'b1, 10);
    for (int i = 0; i < 10; i++) begin
      bus.BTN_UP     = 1'($urandom);
      bus.BTN_DOWN   = 1'($urandom);
      bus.BTN_CENTRE = 1'($urandom);
      cyc(1);
    end
    #3;
    rst_n = 1'b0;
    #1;
    m_row   = 0;
    m_flags = 5'b01111;
    check_all("async_rst");
    bus.BTN_UP     = 1'b0;
    bus.BTN_DOWN   = 1'b0;
    bus.BTN_CENTRE = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(DB + 8);
    check_all("after_rst");

    // Button held across reset gives exactly one step afterwards.
    press(1'b0, 1'b1, 1'b0, 10);
    bus.BTN_UP = 1'b1;
    cyc(3);
    rst_n = 1'b0;
    cyc(3);
    m_row   = 0;
    m_flags = 5'b01111;
    check_all("held_rst");
    rst_n = 1'b1;
    cyc(12);
    bus.BTN_UP = 1'b0;
    cyc(DB + 8);
    model_press(1'b1, 1'b0, 1'b0, 12);
    chk("held_rst.row", 32'(bus.Cursor_Row), 4);
    check_all("held_rst.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
